// File: rtl/mem_lsu.sv
// Load/store unit between a requester and a single-cycle word RAM.
// Handles byte/half/word access, sign extension and read-modify-write for sub-word stores.
module mem_lsu #(
   parameter int ADDR_WIDTH = 32
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  REQ,
   input  logic                  WR,
   input  logic [1:0]            SIZE,
   input  logic                  SIGNED,
   input  logic [ADDR_WIDTH-1:0] ADDR,
   input  logic [31:0]           WDATA,
   output logic                  BUSY,
   output logic                  DONE,
   output logic [31:0]           RDATA,
   output logic                  ERR,
   output logic [ADDR_WIDTH-1:0] MA,
   output logic [31:0]           MWD,
   output logic                  MWE,
   input  logic [31:0]           MRD
);

   // state | meaning
   // IDLE  | waiting for REQ
   // READ  | RAM word read (load result or RMW base)
   // WRITE | MWE asserted with the final word
   // FIN   | DONE pulse (ERR too if rejected)
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_READ  = 2'd1;
   localparam logic [1:0] S_WRITE = 2'd2;
   localparam logic [1:0] S_FIN   = 2'd3;

   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_WORD = 2'd2;

   logic [1:0]            state;
   logic                  wr_q;
   logic [1:0]            size_q;
   logic                  sgn_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [31:0]           wdata_q;
   logic                  err_q;
   logic [31:0]           old_q;
   logic [31:0]           rdata_q;

   logic                  reject;
   logic [4:0]            byte_sh;
   logic [4:0]            half_sh;
   logic [7:0]            lane_b;
   logic [15:0]           lane_h;
   logic [31:0]           load_val;
   logic [31:0]           merged;

   always_comb begin
      reject = 1'b0;
      case (SIZE)
         SZ_BYTE: reject = 1'b0;
         SZ_HALF: reject = ADDR[0];
         SZ_WORD: reject = (ADDR[1:0] != 2'b00);
         default: reject = 1'b1;
      endcase
   end

   assign byte_sh = {addr_q[1:0], 3'b000};
   assign half_sh = {addr_q[1], 4'b0000};
   assign lane_b  = MRD[byte_sh +: 8];
   assign lane_h  = MRD[half_sh +: 16];

   always_comb begin
      load_val = MRD;
      case (size_q)
         SZ_BYTE: load_val = {{24{sgn_q & lane_b[7]}}, lane_b};
         SZ_HALF: load_val = {{16{sgn_q & lane_h[15]}}, lane_h};
         default: load_val = MRD;
      endcase
   end

   // Word stores skip READ, so old_q is stale for them and must not be used.
   always_comb begin
      merged = old_q;
      case (size_q)
         SZ_BYTE: merged[byte_sh +: 8]  = wdata_q[7:0];
         SZ_HALF: merged[half_sh +: 16] = wdata_q[15:0];
         default: merged = wdata_q;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state   <= S_IDLE;
         wr_q    <= 1'b0;
         size_q  <= 2'b00;
         sgn_q   <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         err_q   <= 1'b0;
         old_q   <= '0;
         rdata_q <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (REQ) begin
                  wr_q    <= WR;
                  size_q  <= SIZE;
                  sgn_q   <= SIGNED;
                  addr_q  <= ADDR;
                  wdata_q <= WDATA;
                  err_q   <= reject;
                  if (reject)
                     state <= S_FIN;
                  else if (WR && (SIZE == SZ_WORD))
                     state <= S_WRITE;
                  else
                     state <= S_READ;
               end
            end
            S_READ: begin
               if (wr_q) begin
                  old_q <= MRD;
                  state <= S_WRITE;
               end else begin
                  rdata_q <= load_val;
                  state   <= S_FIN;
               end
            end
            S_WRITE: state <= S_FIN;
            S_FIN:   state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   assign BUSY  = (state != S_IDLE);
   assign DONE  = (state == S_FIN);
   assign ERR   = (state == S_FIN) & err_q;
   assign MWE   = (state == S_WRITE);
   assign MWD   = (state == S_WRITE) ? merged : 32'h0;
   assign MA    = {2'b00, addr_q[ADDR_WIDTH-1:2]};
   assign RDATA = rdata_q;

endmodule
